axi2paxi_arb: RTL and testbench

//  Merges AXI AW and AR address channels into one packed command stream (paxi_a*).

---
 rtl/paxi_pkg.sv | 39 +++
 rtl/paxi_cmd_fifo.sv | 115 +++++++++++
 rtl/axi2paxi_arb.sv | 174 +++++++++++++++++
 tb/tb_axi2paxi_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paxi_pkg.sv
// ---------------------------------------------------------------------------
// paxi_pkg
// Shared types and constants for the AXI AW/AR -> packed command (paxi) path.
//   paxi_cmd_t  : one queued command, default-width view (32-bit address,
//                 4-bit ID) as seen on the paxi_a* head outputs.
//   arb_mode_e  : arbitration policy selector for axi2paxi_arb.
//   ATYPE_*     : command type tag carried with every command.
//   cmd_width() : flat bit width of a command for arbitrary address/ID widths.
// ---------------------------------------------------------------------------
package paxi_pkg;

  localparam int PAXI_ADDR_W = 32;
  localparam int PAXI_ID_W   = 4;

  localparam logic ATYPE_WRITE = 1'b1;
  localparam logic ATYPE_READ  = 1'b0;

  typedef enum logic [1:0] {
    ARB_WR_PRIO       = 2'd0,
    ARB_RR            = 2'd1,
    ARB_WR_PRIO_LIMIT = 2'd2
  } arb_mode_e;

  // Field order matches the flat packing used by axi2paxi_arb.
  typedef struct packed {
    logic [PAXI_ADDR_W-1:0] addr;
    logic [PAXI_ID_W-1:0]   id;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   atype;
  } paxi_cmd_t;

  // addr + id + len(8) + size(3) + burst(2) + atype(1)
  function automatic int cmd_width(input int addr_w, input int id_w);
    return addr_w + id_w + 8 + 3 + 2 + 1;
  endfunction

endpackage

// File: rtl/paxi_cmd_fifo.sv
// ---------------------------------------------------------------------------
// paxi_cmd_fifo
// DEPTH-entry command FIFO with a registered head output. The head register
// is reloaded whenever the FIFO front changes, so a command pushed into an
// empty FIFO is visible on data_o/valid_o on the following cycle, and the
// head holds stable while it is not popped.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push_i        write push_data_i (ignored when full)
//   push_data_i   command to enqueue
//   pop_i         remove head (ignored when empty)
//   data_o        head command, all zeros after reset
//   valid_o       head command valid
//   level_o       occupancy, 0..DEPTH
//   full_o        level_o == DEPTH
// ---------------------------------------------------------------------------
module paxi_cmd_fifo
  import paxi_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & valid_q;

  // Next-state for storage, pointers, occupancy and the registered head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    valid_d  = valid_q;

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // mem_d already holds this cycle's push, which covers the
    // push-into-empty and push-while-popping-last cases.
    valid_d = (level_d != {LVL_W{1'b0}});
    if (valid_d) begin
      data_d = mem_d[rd_ptr_d];
    end else begin
      data_d = data_q;
    end
  end

  // State registers; reset discards every queued command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      data_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign level_o = level_q;

endmodule

// File: rtl/axi2paxi_arb.sv
// ---------------------------------------------------------------------------
// axi2paxi_arb
// Merges the AXI AW and AR address channels into a single packed command
// stream for the memory controller front end. Each accepted address is
// tagged write/read and queued in a DEPTH-entry FIFO; the FIFO head drives
// paxi_a*.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   axi_aw*/axi_awvalid  write address channel in, axi_awready out
//   axi_ar*/axi_arvalid  read address channel in, axi_arready out
//   paxi_a*, paxi_atype  head command (atype 1=write, 0=read)
//   paxi_avalid          head valid; paxi_aready from the consumer pops it
//   paxi_level           FIFO occupancy
// Arbitration (ARB_MODE): 0 write priority, 1 round robin, 2 write priority
// with at most MAX_WR_STREAK consecutive writes while a read is waiting.
// Readies depend only on registered state and the input valids, so the
// consumer's paxi_aready has no combinational path to axi_*ready.
// ---------------------------------------------------------------------------
module axi2paxi_arb
  import paxi_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int DEPTH         = 4,
  parameter int ARB_MODE      = 0,
  parameter int MAX_WR_STREAK = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ADDR_WIDTH-1:0]   paxi_aaddr,
  output logic [ID_WIDTH-1:0]     paxi_aid,
  output logic [7:0]              paxi_alen,
  output logic [2:0]              paxi_asize,
  output logic [1:0]              paxi_aburst,
  output logic                    paxi_atype,
  output logic                    paxi_avalid,
  input  logic                    paxi_aready,
  output logic [$clog2(DEPTH):0]  paxi_level
);

  localparam int        CMD_W      = cmd_width(ADDR_WIDTH, ID_WIDTH);
  localparam int        STREAK_W   = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
  localparam arb_mode_e MODE       = arb_mode_e'(ARB_MODE);

  logic                full_s;
  logic                grant_w_s;
  logic                grant_r_s;
  logic                aw_acc_s;
  logic                ar_acc_s;
  logic                push_s;
  logic                pop_s;
  logic [CMD_W-1:0]    push_data_s;
  logic [CMD_W-1:0]    head_data_s;
  // 1 = the last accepted command was a write; reset as "read last" so a
  // write wins the first round-robin tie.
  logic                rr_last_w_q, rr_last_w_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Channel grant for the selected policy; masked by full below.
  always_comb begin
    grant_w_s = 1'b0;
    grant_r_s = 1'b0;
    case (MODE)
      ARB_WR_PRIO: begin
        grant_w_s = axi_awvalid;
        grant_r_s = axi_arvalid & ~axi_awvalid;
      end
      ARB_RR: begin
        if (axi_awvalid && axi_arvalid) begin
          grant_w_s = ~rr_last_w_q;
          grant_r_s = rr_last_w_q;
        end else begin
          grant_w_s = axi_awvalid;
          grant_r_s = axi_arvalid;
        end
      end
      ARB_WR_PRIO_LIMIT: begin
        // A read that has watched MAX_WR_STREAK writes go by wins once.
        if (axi_awvalid && axi_arvalid && (streak_q == STREAK_MAX)) begin
          grant_w_s = 1'b0;
          grant_r_s = 1'b1;
        end else begin
          grant_w_s = axi_awvalid;
          grant_r_s = axi_arvalid & ~axi_awvalid;
        end
      end
      default: begin
        grant_w_s = axi_awvalid;
        grant_r_s = axi_arvalid & ~axi_awvalid;
      end
    endcase
  end

  // No accept while full, even if the head is popped this cycle.
  assign axi_awready = ~full_s & grant_w_s;
  assign axi_arready = ~full_s & grant_r_s;
  assign aw_acc_s    = axi_awready & axi_awvalid;
  assign ar_acc_s    = axi_arready & axi_arvalid;
  assign push_s      = aw_acc_s | ar_acc_s;
  assign pop_s       = paxi_avalid & paxi_aready;

  // Pack the accepted channel into a tagged command.
  always_comb begin
    if (aw_acc_s) begin
      push_data_s = {axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, ATYPE_WRITE};
    end else begin
      push_data_s = {axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, ATYPE_READ};
    end
  end

  // Round-robin history and write-streak counter, moved only by handshakes.
  always_comb begin
    if (aw_acc_s) begin
      rr_last_w_d = 1'b1;
    end else if (ar_acc_s) begin
      rr_last_w_d = 1'b0;
    end else begin
      rr_last_w_d = rr_last_w_q;
    end

    // The streak only counts writes that overtook a waiting read.
    if (!axi_arvalid || ar_acc_s) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (aw_acc_s && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_w_q <= 1'b0;
      streak_q    <= {STREAK_W{1'b0}};
    end else begin
      rr_last_w_q <= rr_last_w_d;
      streak_q    <= streak_d;
    end
  end

  paxi_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .data_o      (head_data_s),
    .valid_o     (paxi_avalid),
    .level_o     (paxi_level),
    .full_o      (full_s)
  );

  assign {paxi_aaddr, paxi_aid, paxi_alen, paxi_asize, paxi_aburst, paxi_atype} = head_data_s;

endmodule

// File: tb/tb_axi2paxi_arb.sv
`timescale 1ns/1ps
// Three DUT instances (mode 0, 1, 2; DEPTH=4; MAX_WR_STREAK=2) each driven by
// their own AXI masters and compared against a queue-level reference model.
module tb_axi2paxi_arb;
  import paxi_pkg::*;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int MAXS  = 2;

  logic clk;
  logic rst;

  logic [31:0] aw_addr [NI];
  logic [3:0]  aw_id   [NI];
  logic [7:0]  aw_len  [NI];
  logic [2:0]  aw_size [NI];
  logic [1:0]  aw_burst[NI];
  logic        aw_valid[NI];
  logic        aw_ready[NI];
  logic [31:0] ar_addr [NI];
  logic [3:0]  ar_id   [NI];
  logic [7:0]  ar_len  [NI];
  logic [2:0]  ar_size [NI];
  logic [1:0]  ar_burst[NI];
  logic        ar_valid[NI];
  logic        ar_ready[NI];
  logic [31:0] p_addr  [NI];
  logic [3:0]  p_id    [NI];
  logic [7:0]  p_len   [NI];
  logic [2:0]  p_size  [NI];
  logic [1:0]  p_burst [NI];
  logic        p_atype [NI];
  logic        p_avalid[NI];
  logic        p_aready[NI];
  logic [2:0]  p_level [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi2paxi_arb #(
      .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH), .ARB_MODE(g), .MAX_WR_STREAK(MAXS)
    ) u_dut (
      .clk(clk), .rst(rst),
      .axi_awaddr(aw_addr[g]), .axi_awid(aw_id[g]), .axi_awlen(aw_len[g]),
      .axi_awsize(aw_size[g]), .axi_awburst(aw_burst[g]),
      .axi_awvalid(aw_valid[g]), .axi_awready(aw_ready[g]),
      .axi_araddr(ar_addr[g]), .axi_arid(ar_id[g]), .axi_arlen(ar_len[g]),
      .axi_arsize(ar_size[g]), .axi_arburst(ar_burst[g]),
      .axi_arvalid(ar_valid[g]), .axi_arready(ar_ready[g]),
      .paxi_aaddr(p_addr[g]), .paxi_aid(p_id[g]), .paxi_alen(p_len[g]),
      .paxi_asize(p_size[g]), .paxi_aburst(p_burst[g]), .paxi_atype(p_atype[g]),
      .paxi_avalid(p_avalid[g]), .paxi_aready(p_aready[g]), .paxi_level(p_level[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, a list of queued commands in acceptance
  // order plus the arbitration history the rules refer to.
  paxi_cmd_t mq [NI][8];
  int        mcnt     [NI];
  logic      m_last_w [NI];
  int        m_streak [NI];
  logic      exp_awr  [NI];
  logic      exp_arr  [NI];

  int n_checks;
  int n_pass;

  function automatic paxi_cmd_t aw_cmd(input int m);
    paxi_cmd_t c;
    c.addr = aw_addr[m]; c.id = aw_id[m]; c.len = aw_len[m];
    c.size = aw_size[m]; c.burst = aw_burst[m]; c.atype = ATYPE_WRITE;
    return c;
  endfunction

  function automatic paxi_cmd_t ar_cmd(input int m);
    paxi_cmd_t c;
    c.addr = ar_addr[m]; c.id = ar_id[m]; c.len = ar_len[m];
    c.size = ar_size[m]; c.burst = ar_burst[m]; c.atype = ATYPE_READ;
    return c;
  endfunction

  function automatic paxi_cmd_t obs(input int m);
    paxi_cmd_t c;
    c.addr = p_addr[m]; c.id = p_id[m]; c.len = p_len[m];
    c.size = p_size[m]; c.burst = p_burst[m]; c.atype = p_atype[m];
    return c;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      mcnt[m] = 0; m_last_w[m] = 1'b0; m_streak[m] = 0;
    end
  endtask

  // Which channel the rules say is accepted this cycle.
  task automatic model_eval();
    for (int m = 0; m < NI; m++) begin
      logic both, gw;
      both = aw_valid[m] && ar_valid[m];
      case (m)
        1:       gw = both ? !m_last_w[m] : aw_valid[m];
        2:       gw = aw_valid[m] && !(both && m_streak[m] == MAXS);
        default: gw = aw_valid[m];
      endcase
      exp_awr[m] = (mcnt[m] < DEPTH) && gw;
      exp_arr[m] = (mcnt[m] < DEPTH) && ar_valid[m] && !gw;
    end
  endtask

  task automatic model_commit();
    for (int m = 0; m < NI; m++) begin
      if (mcnt[m] > 0 && p_aready[m]) begin
        for (int i = 0; i < 7; i++) mq[m][i] = mq[m][i+1];
        mcnt[m]--;
      end
      if (exp_awr[m]) begin
        mq[m][mcnt[m]] = aw_cmd(m); mcnt[m]++;
        m_last_w[m] = 1'b1;
        if (ar_valid[m]) m_streak[m] = (m_streak[m] < MAXS) ? m_streak[m] + 1 : MAXS;
      end else if (exp_arr[m]) begin
        mq[m][mcnt[m]] = ar_cmd(m); mcnt[m]++;
        m_last_w[m] = 1'b0;
        m_streak[m] = 0;
      end
      if (!ar_valid[m]) m_streak[m] = 0;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Clock edge: model follows the handshakes, masters drop accepted valids.
  task automatic advance();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
    for (int m = 0; m < NI; m++) begin
      if (exp_awr[m]) aw_valid[m] = 1'b0;
      if (exp_arr[m]) ar_valid[m] = 1'b0;
    end
  endtask

  task automatic new_aw(input int m);
    aw_addr[m] = $urandom; aw_id[m] = 4'($urandom); aw_len[m] = 8'($urandom);
    aw_size[m] = 3'($urandom); aw_burst[m] = 2'($urandom); aw_valid[m] = 1'b1;
  endtask

  task automatic new_ar(input int m);
    ar_addr[m] = $urandom; ar_id[m] = 4'($urandom); ar_len[m] = 8'($urandom);
    ar_size[m] = 3'($urandom); ar_burst[m] = 2'($urandom); ar_valid[m] = 1'b1;
  endtask

  task automatic do_reset();
    for (int m = 0; m < NI; m++) begin
      aw_valid[m] = 1'b0; ar_valid[m] = 1'b0; p_aready[m] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int m = 0; m < NI; m++) begin
      n_checks++; if (p_avalid[m] !== 1'b0) $display("FAIL reset_avalid inst%0d got %b exp 0", m, p_avalid[m]); else n_pass++;
      n_checks++; if (p_level[m] !== 3'd0) $display("FAIL reset_level inst%0d got %0d exp 0", m, p_level[m]); else n_pass++;
      n_checks++; if (obs(m) !== paxi_cmd_t'(0)) $display("FAIL reset_data inst%0d got %h exp 0", m, obs(m)); else n_pass++;
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_aw_only();
    for (int m = 0; m < NI; m++) begin
      aw_addr[m] = 32'h1000; aw_id[m] = 4'd3; aw_len[m] = 8'd7; aw_size[m] = 3'd2; aw_burst[m] = 2'd1;
      aw_valid[m] = 1'b1; ar_valid[m] = 1'b0; p_aready[m] = 1'b0;
    end
    settle();
    for (int m = 0; m < NI; m++) begin
      n_checks++; if (aw_ready[m] !== 1'b1) $display("FAIL aw_only_awready inst%0d got %b exp 1", m, aw_ready[m]); else n_pass++;
    end
    advance();
    settle();
    for (int m = 0; m < NI; m++) begin
      n_checks++; if (p_avalid[m] !== 1'b1) $display("FAIL aw_only_avalid inst%0d got %b exp 1", m, p_avalid[m]); else n_pass++;
      n_checks++;
      if (p_addr[m] !== 32'h1000 || p_id[m] !== 4'd3 || p_len[m] !== 8'd7 || p_atype[m] !== 1'b1)
        $display("FAIL aw_only_head inst%0d got addr=%h id=%0d len=%0d atype=%b exp 1000/3/7/1", m, p_addr[m], p_id[m], p_len[m], p_atype[m]);
      else n_pass++;
      n_checks++; if (p_level[m] !== 3'd1) $display("FAIL aw_only_level inst%0d got %0d exp 1", m, p_level[m]); else n_pass++;
      p_aready[m] = 1'b1;
    end
    advance();
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b0;
    settle();
    for (int m = 0; m < NI; m++) begin
      n_checks++; if (p_level[m] !== 3'd0) $display("FAIL aw_only_drain inst%0d got %0d exp 0", m, p_level[m]); else n_pass++;
    end
  endtask

  task automatic test_wr_prio();
    paxi_cmd_t rc;
    do_reset();
    for (int m = 0; m < NI; m++) begin
      new_ar(m); p_aready[m] = 1'b1;
    end
    rc = ar_cmd(0);
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < NI; m++) new_aw(m);
      settle();
      n_checks++; if (aw_ready[0] !== 1'b1) $display("FAIL wrprio_awready cyc%0d got %b exp 1", k, aw_ready[0]); else n_pass++;
      n_checks++; if (ar_ready[0] !== 1'b0) $display("FAIL wrprio_arready cyc%0d got %b exp 0", k, ar_ready[0]); else n_pass++;
      advance();
    end
    for (int m = 0; m < NI; m++) aw_valid[m] = 1'b0;
    settle();
    n_checks++; if (ar_ready[0] !== 1'b1) $display("FAIL wrprio_read_issue got %b exp 1", ar_ready[0]); else n_pass++;
    advance();
    settle();
    n_checks++; if (obs(0) !== rc || p_avalid[0] !== 1'b1) $display("FAIL wrprio_read_head got %h exp %h", obs(0), rc); else n_pass++;
  endtask

  task automatic test_rr();
    do_reset();
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < NI; m++) begin new_aw(m); new_ar(m); end
      settle();
      n_checks++;
      if (aw_ready[1] !== (k % 2 == 0) || ar_ready[1] !== (k % 2 == 1))
        $display("FAIL rr_grant cyc%0d got aw=%b ar=%b exp aw=%b", k, aw_ready[1], ar_ready[1], (k % 2 == 0));
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (p_avalid[1] !== 1'b1 || p_atype[1] !== ((k - 1) % 2 == 0))
          $display("FAIL rr_atype cyc%0d got v=%b t=%b exp t=%b", k, p_avalid[1], p_atype[1], ((k - 1) % 2 == 0));
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_streak();
    do_reset();
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int m = 0; m < NI; m++) begin new_aw(m); new_ar(m); end
      settle();
      n_checks++;
      if (aw_ready[2] !== (k % 3 != 2) || ar_ready[2] !== (k % 3 == 2))
        $display("FAIL streak_grant cyc%0d got aw=%b ar=%b exp aw=%b", k, aw_ready[2], ar_ready[2], (k % 3 != 2));
      else n_pass++;
      n_checks++; if (aw_ready[0] !== 1'b1) $display("FAIL streak_mode0_awready cyc%0d got %b exp 1", k, aw_ready[0]); else n_pass++;
      advance();
    end
  endtask

  task automatic test_full();
    paxi_cmd_t cs[5];
    paxi_cmd_t exp_seq[5];
    paxi_cmd_t rc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < NI; m++) begin
        aw_addr[m] = 32'h2000 + 32'(k * 16); aw_id[m] = 4'(k); aw_len[m] = 8'(k + 1);
        aw_size[m] = 3'd3; aw_burst[m] = 2'd1; aw_valid[m] = 1'b1;
      end
      cs[k] = aw_cmd(0);
      settle();
      n_checks++; if (aw_ready[0] !== 1'b1) $display("FAIL full_fill_awready k%0d got %b exp 1", k, aw_ready[0]); else n_pass++;
      advance();
    end
    for (int m = 0; m < NI; m++) begin
      aw_addr[m] = 32'h3000; aw_id[m] = 4'd9; aw_len[m] = 8'd4; aw_valid[m] = 1'b1;
      new_ar(m); ar_addr[m] = ar_addr[0]; ar_id[m] = ar_id[0]; ar_len[m] = ar_len[0];
      ar_size[m] = ar_size[0]; ar_burst[m] = ar_burst[0];
    end
    cs[4] = aw_cmd(0);
    rc = ar_cmd(0);
    for (int h = 0; h < 2; h++) begin
      settle();
      for (int m = 0; m < NI; m++) begin
        n_checks++; if (p_level[m] !== 3'd4) $display("FAIL full_level inst%0d got %0d exp 4", m, p_level[m]); else n_pass++;
        n_checks++; if (aw_ready[m] !== 1'b0 || ar_ready[m] !== 1'b0) $display("FAIL full_ready inst%0d got aw=%b ar=%b exp 0/0", m, aw_ready[m], ar_ready[m]); else n_pass++;
      end
      n_checks++; if (obs(0) !== cs[0] || p_avalid[0] !== 1'b1) $display("FAIL full_head_hold h%0d got %h exp %h", h, obs(0), cs[0]); else n_pass++;
      advance();
    end
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b1;
    settle();
    n_checks++; if (aw_ready[0] !== 1'b0) $display("FAIL full_pop_noaccept got %b exp 0", aw_ready[0]); else n_pass++;
    advance();
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b0;
    settle();
    n_checks++; if (p_level[0] !== 3'd3) $display("FAIL full_after_pop_level got %0d exp 3", p_level[0]); else n_pass++;
    n_checks++; if (aw_ready[0] !== 1'b1 || ar_ready[0] !== 1'b0) $display("FAIL full_refill_grant got aw=%b ar=%b exp 1/0", aw_ready[0], ar_ready[0]); else n_pass++;
    advance();
    settle();
    n_checks++; if (p_level[0] !== 3'd4) $display("FAIL full_refill_level got %0d exp 4", p_level[0]); else n_pass++;
    exp_seq[0] = cs[1]; exp_seq[1] = cs[2]; exp_seq[2] = cs[3]; exp_seq[3] = cs[4]; exp_seq[4] = rc;
    for (int m = 0; m < NI; m++) p_aready[m] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      settle();
      n_checks++; if (obs(0) !== exp_seq[j] || p_avalid[0] !== 1'b1) $display("FAIL full_order j%0d got %h exp %h", j, obs(0), exp_seq[j]); else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    paxi_cmd_t c;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < NI; m++) new_aw(m);
      settle();
      advance();
    end
    settle();
    n_checks++; if (p_level[0] !== 3'd3) $display("FAIL rstmid_prefill got %0d exp 3", p_level[0]); else n_pass++;
    #1; rst = 1'b1; #1;
    for (int m = 0; m < NI; m++) begin
      n_checks++; if (p_avalid[m] !== 1'b0 || p_level[m] !== 3'd0) $display("FAIL rstmid_async inst%0d got v=%b lvl=%0d exp 0/0", m, p_avalid[m], p_level[m]); else n_pass++;
      n_checks++; if (obs(m) !== paxi_cmd_t'(0)) $display("FAIL rstmid_data inst%0d got %h exp 0", m, obs(m)); else n_pass++;
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int m = 0; m < NI; m++) new_aw(m);
    c = aw_cmd(0);
    settle();
    n_checks++; if (aw_ready[0] !== 1'b1) $display("FAIL rstmid_accept got %b exp 1", aw_ready[0]); else n_pass++;
    advance();
    settle();
    n_checks++; if (obs(0) !== c || p_avalid[0] !== 1'b1 || p_level[0] !== 3'd1) $display("FAIL rstmid_issue got %h lvl=%0d exp %h lvl=1", obs(0), p_level[0], c); else n_pass++;
  endtask

  task automatic test_random();
    int pr;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      case (cyc / 200)
        0:       pr = 80;
        1:       pr = 25;
        2:       pr = 100;
        default: pr = 10;
      endcase
      for (int m = 0; m < NI; m++) begin
        if (!aw_valid[m] && $urandom_range(0, 99) < 55) new_aw(m);
        if (!ar_valid[m] && $urandom_range(0, 99) < 45) new_ar(m);
        p_aready[m] = ($urandom_range(0, 99) < pr);
      end
      settle();
      for (int m = 0; m < NI; m++) begin
        n_checks++; if (aw_ready[m] !== exp_awr[m]) $display("FAIL rnd_awready inst%0d cyc%0d got %b exp %b", m, cyc, aw_ready[m], exp_awr[m]); else n_pass++;
        n_checks++; if (ar_ready[m] !== exp_arr[m]) $display("FAIL rnd_arready inst%0d cyc%0d got %b exp %b", m, cyc, ar_ready[m], exp_arr[m]); else n_pass++;
        n_checks++; if (p_avalid[m] !== (mcnt[m] > 0)) $display("FAIL rnd_avalid inst%0d cyc%0d got %b exp %b", m, cyc, p_avalid[m], (mcnt[m] > 0)); else n_pass++;
        n_checks++; if (p_level[m] !== 3'(mcnt[m])) $display("FAIL rnd_level inst%0d cyc%0d got %0d exp %0d", m, cyc, p_level[m], mcnt[m]); else n_pass++;
        if (mcnt[m] > 0) begin
          n_checks++; if (obs(m) !== mq[m][0]) $display("FAIL rnd_head inst%0d cyc%0d got %h exp %h", m, cyc, obs(m), mq[m][0]); else n_pass++;
        end
      end
      advance();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    for (int m = 0; m < NI; m++) begin
      aw_addr[m] = 32'h0; aw_id[m] = 4'h0; aw_len[m] = 8'h0; aw_size[m] = 3'h0; aw_burst[m] = 2'h0;
      ar_addr[m] = 32'h0; ar_id[m] = 4'h0; ar_len[m] = 8'h0; ar_size[m] = 3'h0; ar_burst[m] = 2'h0;
      aw_valid[m] = 1'b0; ar_valid[m] = 1'b0; p_aready[m] = 1'b0;
    end
    model_reset();
    test_reset();
    test_aw_only();
    test_wr_prio();
    test_rr();
    test_streak();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
